// File: rtl/wm8731_i2c_slave.sv
// WM8731 control-port responder: acknowledges 3-byte I2C writes into a 9-bit register file.
// Define NACK_INVALID_REG_EN to NACK writes to unimplemented registers (other than the reset register).
`timescale 1ns/1ps
module wm8731_i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         NUM_REGS = 10
) (
  input  logic       clock_50m,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  input  logic [3:0] rd_index,
  output logic [8:0] rd_data,
  output logic       reg_we,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_wdata,
  output logic       codec_active,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE} state_e;

  localparam logic [6:0] RESET_REG = 7'h0F;

  function automatic logic [8:0] reg_default(input int idx);
    case (idx)
      0, 1:    return 9'h097;
      2, 3:    return 9'h079;
      4:       return 9'h00A;
      5:       return 9'h008;
      6:       return 9'h09F;
      7:       return 9'h00A;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic reg_in_range(input logic [6:0] r);
    return 32'(r) < NUM_REGS;
  endfunction

  logic scl_s1_q, scl_s2_q, scl_d_q;
  logic sda_s1_q, sda_s2_q, sda_d_q;
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       full_q, full_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] reg_sel_q, reg_sel_d;
  logic       d8_q, d8_d;
  logic [8:0] regs_q [NUM_REGS];
  logic [8:0] regs_d [NUM_REGS];
  logic       reg_we_q, reg_we_d;
  logic [6:0] reg_addr_q, reg_addr_d;
  logic [8:0] reg_wdata_q, reg_wdata_d;

  logic scl_rise, scl_fall, start_ev, stop_ev;

  // Bus events use the synchronized copies only; START/STOP need SCL high on both samples.
  assign scl_rise = scl_s2_q & ~scl_d_q;
  assign scl_fall = ~scl_s2_q & scl_d_q;
  assign start_ev = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;

  // Open drain: release immediately on reset, never drive high.
  assign i2c_sdat = (sda_low_q && !reset) ? 1'b0 : 1'bz;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    sda_low_d   = sda_low_q;
    shift_d     = shift_q;
    reg_sel_d   = reg_sel_q;
    d8_d        = d8_q;
    regs_d      = regs_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    if (stop_ev) begin
      state_d   = IDLE;
      sda_low_d = 1'b0;
    end else if (start_ev) begin
      state_d   = ADDR;
      sda_low_d = 1'b0;
      cnt_d     = 3'd0;
      full_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, BYTE1, BYTE2: begin
          if (scl_rise && !full_q) begin
            shift_d = {shift_q[6:0], sda_s2_q};
            if (cnt_q == 3'd7) full_d = 1'b1;
            else               cnt_d  = cnt_q + 3'd1;
          end else if (scl_fall && full_q) begin
            case (state_q)
              ADDR: begin
                if (shift_q == {DEV_ADDR, 1'b0}) begin
                  sda_low_d = 1'b1;
                  state_d   = ACK_A;
                end else begin
                  sda_low_d = 1'b0;
                  state_d   = IGNORE;
                end
              end
              BYTE1: begin
                reg_sel_d = shift_q[7:1];
                d8_d      = shift_q[0];
`ifdef NACK_INVALID_REG_EN
                if (!reg_in_range(shift_q[7:1]) && shift_q[7:1] != RESET_REG) begin
                  sda_low_d = 1'b0;
                  state_d   = IGNORE;
                end else begin
                  sda_low_d = 1'b1;
                  state_d   = ACK_1;
                end
`else
                sda_low_d = 1'b1;
                state_d   = ACK_1;
`endif
              end
              default: begin
                // Commit on the same edge that starts the final ACK.
                sda_low_d   = 1'b1;
                state_d     = ACK_2;
                reg_we_d    = 1'b1;
                reg_addr_d  = reg_sel_q;
                reg_wdata_d = {d8_q, shift_q};
                if (reg_sel_q == RESET_REG) begin
                  for (int i = 0; i < NUM_REGS; i++) regs_d[i] = reg_default(i);
                end else if (reg_in_range(reg_sel_q)) begin
                  for (int i = 0; i < NUM_REGS; i++)
                    if (reg_sel_q == 7'(i)) regs_d[i] = {d8_q, shift_q};
                end
              end
            endcase
          end
        end
        ACK_A, ACK_1, ACK_2: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            cnt_d     = 3'd0;
            full_d    = 1'b0;
            case (state_q)
              ACK_A:   state_d = BYTE1;
              ACK_1:   state_d = BYTE2;
              default: state_d = IGNORE;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_50m) begin
    scl_s1_q <= i2c_sclk;
    scl_s2_q <= scl_s1_q;
    scl_d_q  <= scl_s2_q;
    sda_s1_q <= i2c_sdat;
    sda_s2_q <= sda_s1_q;
    sda_d_q  <= sda_s2_q;
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      full_q      <= 1'b0;
      sda_low_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= 7'd0;
      reg_wdata_q <= 9'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reg_default(i);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      sda_low_q   <= sda_low_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      regs_q      <= regs_d;
    end
  end

  always_ff @(posedge clock_50m) begin
    shift_q   <= shift_d;
    reg_sel_q <= reg_sel_d;
    d8_q      <= d8_d;
  end

  always_comb begin
    rd_data = 9'h000;
    for (int i = 0; i < NUM_REGS; i++)
      if (rd_index == 4'(i)) rd_data = regs_q[i];
  end

  assign reg_we       = reg_we_q;
  assign reg_addr     = reg_addr_q;
  assign reg_wdata    = reg_wdata_q;
  assign codec_active = regs_q[9][0];
  assign busy         = (state_q != IDLE);

endmodule
